// File: rtl/memory_stage_ctrl_if.sv
// Bundles the EX/MEM slot, the data-memory handshake and the MEM/WB register outputs
// seen by the memory-stage controller.
interface memory_stage_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] alu_in;
  logic              z_in;
  logic [DATA_W-1:0] b_in;
  logic [1:0]        vsel_in;
  logic [1:0]        mem_cmd_in;
  logic [2:0]        write_num_in;
  logic              write_in;
  logic              stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] wb_data;
  logic [2:0]        wb_num;
  logic              wb_write;
  logic              wb_z;
  logic              mem_err;

  // The controller owns the memory request and the MEM/WB register.
  modport master (
    input  in_valid, alu_in, z_in, b_in, vsel_in, mem_cmd_in, write_num_in, write_in,
    input  mem_ack, mem_rdata,
    output stall, mem_req, mem_we, mem_addr, mem_wdata,
    output wb_data, wb_num, wb_write, wb_z, mem_err
  );

  modport slave (
    output in_valid, alu_in, z_in, b_in, vsel_in, mem_cmd_in, write_num_in, write_in,
    output mem_ack, mem_rdata,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_data, wb_num, wb_write, wb_z, mem_err
  );
endinterface

// File: rtl/memory_stage_ctrl.sv
// Memory pipeline stage: consumes the EX/MEM slot, runs a req/ack data-memory access when
// needed and loads the MEM/WB register; stalls upstream while an access is outstanding.
module memory_stage_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input logic                clk,
  input logic                reset,
  memory_stage_ctrl_if.master bus
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              memReq_q, memReq_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [1:0]        vsel_q, vsel_d;
  logic [2:0]        num_q, num_d;
  logic              write_q, write_d;
  logic              z_q, z_d;
  logic [DATA_W-1:0] wbData_q, wbData_d;
  logic [2:0]        wbNum_q, wbNum_d;
  logic              wbWrite_q, wbWrite_d;
  logic              wbZ_q, wbZ_d;
  logic              memErr_q, memErr_d;
  logic              isMem;

  // Only load (01) and store (10) touch memory; 11 behaves like no command.
  assign isMem = (bus.mem_cmd_in == 2'b01) || (bus.mem_cmd_in == 2'b10);

  assign bus.stall = !reset &&
                     (((state_q == IDLE) && bus.in_valid && isMem) || (state_q == REQ));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    alu_d      = alu_q;
    vsel_d     = vsel_q;
    num_d      = num_q;
    write_d    = write_q;
    z_d        = z_q;
    wbData_d   = wbData_q;
    wbNum_d    = wbNum_q;
    wbWrite_d  = wbWrite_q;
    wbZ_d      = wbZ_q;
    memErr_d   = memErr_q;

    unique case (state_q)
      IDLE: begin
        if (!bus.in_valid) begin
          wbWrite_d = 1'b0;
        end else if (isMem) begin
          memAddr_d  = bus.alu_in[ADDR_W-1:0];
          memWdata_d = bus.b_in;
          alu_d      = bus.alu_in;
          vsel_d     = bus.vsel_in;
          num_d      = bus.write_num_in;
          write_d    = bus.write_in;
          z_d        = bus.z_in;
          memReq_d   = 1'b1;
          memWe_d    = (bus.mem_cmd_in == 2'b10);
          cnt_d      = '0;
          wbWrite_d  = 1'b0;
          state_d    = REQ;
        end else begin
          wbData_d  = bus.alu_in;
          wbNum_d   = bus.write_num_in;
          wbWrite_d = bus.write_in;
          wbZ_d     = bus.z_in;
        end
      end

      REQ: begin
        // An ack in the final wait cycle still completes the access normally.
        if (bus.mem_ack) begin
          memReq_d = 1'b0;
          wbNum_d  = num_q;
          wbZ_d    = z_q;
          if (!memWe_q) begin
            wbData_d  = (vsel_q == 2'b11) ? bus.mem_rdata : alu_q;
            wbWrite_d = write_q;
          end else begin
            wbWrite_d = 1'b0;
          end
          state_d = DONE;
        end else if (cnt_q == LAST_WAIT) begin
          memReq_d  = 1'b0;
          memErr_d  = 1'b1;
          wbWrite_d = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        wbWrite_d = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      alu_q      <= '0;
      vsel_q     <= '0;
      num_q      <= '0;
      write_q    <= 1'b0;
      z_q        <= 1'b0;
      wbData_q   <= '0;
      wbNum_q    <= '0;
      wbWrite_q  <= 1'b0;
      wbZ_q      <= 1'b0;
      memErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      alu_q      <= alu_d;
      vsel_q     <= vsel_d;
      num_q      <= num_d;
      write_q    <= write_d;
      z_q        <= z_d;
      wbData_q   <= wbData_d;
      wbNum_q    <= wbNum_d;
      wbWrite_q  <= wbWrite_d;
      wbZ_q      <= wbZ_d;
      memErr_q   <= memErr_d;
    end
  end

  assign bus.mem_req   = memReq_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.wb_data   = wbData_q;
  assign bus.wb_num    = wbNum_q;
  assign bus.wb_write  = wbWrite_q;
  assign bus.wb_z      = wbZ_q;
  assign bus.mem_err   = memErr_q;

endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Bench for memory_stage_ctrl: a vector table drives instructions and a memory responder,
// while a scoreboard queue checks every MEM/WB write pulse in order.
module tb_memory_stage_ctrl;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  memory_stage_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memory_stage_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ackDelay: REQ cycle on which mem_ack is raised (0 = never).
  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] alu;
    logic [15:0] b;
    logic        z;
    logic [1:0]  vsel;
    logic [2:0]  num;
    logic        write;
    int          ackDelay;
    logic [15:0] rdata;
    int          expStall;
    int          expReq;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  num;
    logic        z;
  } wbExp_t;

  wbExp_t sbQ[$];
  wbExp_t monExp;
  vec_t   vecs[9];
  int     compared   = 0;
  int     mismatched = 0;
  int     pulses     = 0;
  int     pushes     = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Every cycle with wb_write high is one register-file write and must match the queue head.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.wb_write === 1'b1) begin
      pulses++;
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL wbUnexpected: got write to r%0d data %0h, expected no write",
                 bus.wb_num, bus.wb_data);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("wbData", 32'(bus.wb_data), 32'(monExp.data));
        checkOutput("wbNum", 32'(bus.wb_num), 32'(monExp.num));
        checkOutput("wbZ", 32'(bus.wb_z), 32'(monExp.z));
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    int  stallCycles = 0;
    int  reqCycles   = 0;
    bit  exitOk      = 0;
    bit  isMem;
    wbExp_t e;
    isMem = (v.cmd == 2'b01) || (v.cmd == 2'b10);
    @(negedge clk);
    bus.in_valid     = 1'b1;
    bus.mem_cmd_in   = v.cmd;
    bus.alu_in       = v.alu;
    bus.b_in         = v.b;
    bus.z_in         = v.z;
    bus.vsel_in      = v.vsel;
    bus.write_num_in = v.num;
    bus.write_in     = v.write;
    bus.mem_ack      = 1'b0;
    if (v.write && (!isMem || (v.cmd == 2'b01 && v.ackDelay > 0))) begin
      e.data = (v.cmd == 2'b01 && v.vsel == 2'b11) ? v.rdata : v.alu;
      e.num  = v.num;
      e.z    = v.z;
      sbQ.push_back(e);
      pushes++;
    end
    #1;
    for (int i = 0; i < 40; i++) begin
      if (bus.stall !== 1'b1) begin
        exitOk = 1;
        break;
      end
      stallCycles++;
      if (bus.mem_req === 1'b1) begin
        reqCycles++;
        checkOutput("memAddr", 32'(bus.mem_addr), 32'(v.alu[8:0]));
        checkOutput("memWe", 32'(bus.mem_we), 32'(v.cmd == 2'b10));
        checkOutput("memWdata", 32'(bus.mem_wdata), 32'(v.b));
        checkOutput("wbWriteInReq", 32'(bus.wb_write), 32'd0);
        if (reqCycles == v.ackDelay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = v.rdata;
        end
      end
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'hDEAD;
      #1;
    end
    if (!exitOk) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL stallBound: got stall still high after 40 cycles, expected release");
    end
    checkOutput("stallCycles", 32'(stallCycles), 32'(v.expStall));
    checkOutput("reqCycles", 32'(reqCycles), 32'(v.expReq));
    checkOutput("memReqAfter", 32'(bus.mem_req), 32'd0);
    checkOutput("memErr", 32'(bus.mem_err), 32'(v.expErr));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".memReq"}, 32'(bus.mem_req), 32'd0);
    checkOutput({tag, ".memWe"}, 32'(bus.mem_we), 32'd0);
    checkOutput({tag, ".memAddr"}, 32'(bus.mem_addr), 32'd0);
    checkOutput({tag, ".memWdata"}, 32'(bus.mem_wdata), 32'd0);
    checkOutput({tag, ".wbData"}, 32'(bus.wb_data), 32'd0);
    checkOutput({tag, ".wbNum"}, 32'(bus.wb_num), 32'd0);
    checkOutput({tag, ".wbWrite"}, 32'(bus.wb_write), 32'd0);
    checkOutput({tag, ".wbZ"}, 32'(bus.wb_z), 32'd0);
    checkOutput({tag, ".memErr"}, 32'(bus.mem_err), 32'd0);
    checkOutput({tag, ".stall"}, 32'(bus.stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200us, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t extra;
    //            cmd    alu       b         z     vsel   num   wr    ack rdata     stl req err
    vecs[0] = '{2'b00, 16'h1234, 16'h0000, 1'b0, 2'b00, 3'd3, 1'b1, 0, 16'h0000, 0,  0,  1'b0};
    vecs[1] = '{2'b01, 16'h0105, 16'h0000, 1'b1, 2'b11, 3'd5, 1'b1, 1, 16'hBEEF, 2,  1,  1'b0};
    vecs[2] = '{2'b10, 16'h0010, 16'hCAFE, 1'b0, 2'b00, 3'd2, 1'b1, 3, 16'h0000, 4,  3,  1'b0};
    vecs[3] = '{2'b01, 16'h00AA, 16'h0000, 1'b0, 2'b00, 3'd6, 1'b1, 2, 16'h5555, 3,  2,  1'b0};
    vecs[4] = '{2'b00, 16'h7777, 16'h0000, 1'b0, 2'b00, 3'd1, 1'b0, 0, 16'h0000, 0,  0,  1'b0};
    vecs[5] = '{2'b01, 16'h0040, 16'h0000, 1'b0, 2'b11, 3'd7, 1'b1, 0, 16'h0000, 16, 15, 1'b1};
    vecs[6] = '{2'b00, 16'h4321, 16'h0000, 1'b1, 2'b00, 3'd1, 1'b1, 0, 16'h0000, 0,  0,  1'b1};
    vecs[7] = '{2'b01, 16'hFF05, 16'h0000, 1'b0, 2'b11, 3'd4, 1'b1, 1, 16'h1357, 2,  1,  1'b1};
    vecs[8] = '{2'b11, 16'h0F0F, 16'h0000, 1'b1, 2'b00, 3'd7, 1'b1, 0, 16'h0000, 0,  0,  1'b1};

    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.alu_in       = '0;
    bus.z_in         = 1'b0;
    bus.b_in         = '0;
    bus.vsel_in      = '0;
    bus.mem_cmd_in   = '0;
    bus.write_num_in = '0;
    bus.write_in     = 1'b0;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // A stray ack while idle must not start or finish anything.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h9999;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    checkOutput("strayAck.memReq", 32'(bus.mem_req), 32'd0);
    checkOutput("strayAck.stall", 32'(bus.stall), 32'd0);

    // Reset in the middle of an outstanding load.
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.mem_cmd_in = 2'b01;
    bus.alu_in     = 16'h0033;
    bus.write_in   = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("midReq.memReq", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checkAllZero("midReset");
    bus.in_valid = 1'b0;
    reset        = 1'b0;

    extra = '{2'b00, 16'hA5A5, 16'h0000, 1'b1, 2'b00, 3'd2, 1'b1, 0, 16'h0000, 0, 0, 1'b0};
    applyStimulus(extra);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("sbQueueEmpty", 32'(sbQ.size()), 32'd0);
    checkOutput("wbPulseCount", 32'(pulses), 32'(pushes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
